// File: rtl/data_memory_responder.sv
// Purpose: word-addressed data memory answering single CPU requests with a fixed, parameterised delay.
// Latency: ack is seen on the LATENCY-th rising edge after the accept edge.
// Backpressure: ready is high only while idle; the CPU holds req until it is accepted, and one request is in flight at a time.
module data_memory_responder #(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  nextState;
    logic [3:0]              count;
    logic [3:0]              nextCount;

    logic                    capWe;
    logic [31:0]             capAddr;
    logic [31:0]             capWdata;

    logic                    curWe;
    logic [31:0]             curAddr;
    logic [31:0]             curWdata;
    logic [DEPTH_LOG2-1:0]   wordIdx;
    logic                    fault;
    logic                    enterResp;

    logic [31:0]             mem [0:DEPTH-1];

    // While idle the live request is the one being accepted; afterwards only the captured copy counts.
    always_comb begin
        curWe    = capWe;
        curAddr  = capAddr;
        curWdata = capWdata;
        if (state == IDLE) begin
            curWe    = we;
            curAddr  = addr;
            curWdata = wdata;
        end
    end

    assign wordIdx   = curAddr[DEPTH_LOG2+1:2];
    assign fault     = (curAddr[1:0] != 2'b00) || ((curAddr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign enterResp = (nextState == RESP);

    // Next-state and countdown: accept from IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        nextState = state;
        nextCount = count;
        case (state)
            IDLE: begin
                if (req) begin
                    if (LATENCY > 1) begin
                        nextState = WAIT;
                        nextCount = LAT_M1;
                    end else begin
                        nextState = RESP;
                    end
                end
            end
            WAIT: begin
                nextCount = count - 4'd1;
                if (count == 4'd1) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
                nextCount = 4'd0;
            end
        endcase
    end

    // State and counter register; reset aborts any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            count <= 4'd0;
        end else begin
            state <= nextState;
            count <= nextCount;
        end
    end

    // Capture the request fields on the accept edge so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            capWe    <= 1'b0;
            capAddr  <= 32'd0;
            capWdata <= 32'd0;
        end else if (state == IDLE && req) begin
            capWe    <= we;
            capAddr  <= addr;
            capWdata <= wdata;
        end
    end

    // Memory array: cleared by reset, written on the edge entering RESP for valid writes only.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 32'd0;
            end
        end else if (enterResp && curWe && !fault) begin
            mem[wordIdx] <= curWdata;
        end
    end

    // Registered outputs: ready mirrors IDLE, ack mirrors RESP, data/err only during ack.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ready <= 1'b1;
            ack   <= 1'b0;
            rdata <= 32'd0;
            err   <= 1'b0;
        end else begin
            ready <= (nextState == IDLE);
            ack   <= enterResp;
            rdata <= 32'd0;
            err   <= 1'b0;
            if (enterResp) begin
                err <= fault;
                if (!fault && !curWe) begin
                    rdata <= mem[wordIdx];
                end
            end
        end
    end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, meaning log2 of word count (64 x 32-bit words).
REQ-002 SHALL have parameter LATENCY, default 2, meaning cycles from accept edge to ack edge; legal range 1..15.
REQ-003 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have port req  input  1  CPU request valid; held by CPU until accepted.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read; sampled with req.
REQ-007 SHALL have port addr  input  32  byte address; sampled with req.
REQ-008 SHALL have port wdata  input  32  write data; sampled with req.
REQ-009 SHALL have port ready  output  1  responder idle and accepting a request.
REQ-010 SHALL have port ack  output  1  one-cycle response strobe.
REQ-011 SHALL have port rdata  output  32  read data, valid while ack=1.
REQ-012 SHALL have port err  output  1  request faulted, valid while ack=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; all outputs registered.
REQ-014 SHALL assert ready=1 only in IDLE; ack=1 only in RESP.
REQ-015 SHALL accept a request on a rising edge with rst=1, state=IDLE, req=1; capture we, addr, wdata; leave IDLE.
REQ-016 SHALL, on accept, go to WAIT with counter = LATENCY-1 if LATENCY>1, else go directly to RESP.
REQ-017 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where the counter reads 1.
REQ-018 SHALL place ack in the cycle starting exactly LATENCY edges after the accept edge.
REQ-019 SHALL hold RESP for exactly one cycle, then return to IDLE; no request is accepted from RESP, so there is at least one ready cycle between transactions.
REQ-020 SHALL ignore req, we, addr and wdata while not in IDLE; the captured values are used.
REQ-021 SHALL fault a request if addr[1:0]!=0, or if addr[31:DEPTH_LOG2+2] is nonzero.
REQ-022 SHALL, for a valid write, update mem[addr[DEPTH_LOG2+1:2]] on the edge entering RESP; rdata=0, err=0 during ack.
REQ-023 SHALL, for a valid read, present mem[word index] on rdata during ack, reflecting all earlier committed writes.
REQ-024 SHALL, for a faulted request, leave memory unchanged and drive rdata=0, err=1 during ack.
REQ-025 SHALL drive rdata=0 and err=0 whenever ack=0.
REQ-026 SHALL use word-granular access only; there are no byte enables.

Reset
REQ-027 SHALL, on any edge with rst=0, set state=IDLE, counter=0, ready=1, ack=0, rdata=0, err=0, and clear all memory words to 0.
REQ-028 SHALL abort an in-flight transaction when rst=0 is sampled: no write is committed and no ack is produced.
REQ-029 SHALL take rst priority over the write commit; if rst=0 on the edge entering RESP, the write does not occur.
REQ-030 SHALL accept a request on the first edge with rst=1 if req=1 on that edge.

Verification (LATENCY=2, DEPTH_LOG2=6 unless stated)
REQ-031 Bench SHALL cover: rst=0 for 2 cycles, then release -> ready=1, ack=0, rdata=0, err=0; a read of addr 0x3C returns 0.
REQ-032 Bench SHALL cover: write 0x0000_000C <- 0xDEAD_BEEF, then read 0x0000_000C -> each ack is exactly 2 edges after its accept edge; the read returns 0xDEAD_BEEF with err=0.
REQ-033 Bench SHALL cover: read 0x0000_0006 (misaligned) and write 0x0000_0100 <- 0x1234_5678 (out of range) -> both return err=1, rdata=0; a later read of 0x0000_0000 returns 0.
REQ-034 Bench SHALL cover: req held high continuously over 3 writes -> ready pattern 1,0,0,1 repeats; addr/wdata changes during WAIT have no effect.
REQ-035 Bench SHALL cover: write 0x10 <- 0xA5A5_A5A5 with rst=0 pulsed on the WAIT cycle -> no ack; after reset, a read of 0x10 returns 0.
REQ-036 Bench SHALL cover: rebuild with LATENCY=1, then a read follows a write to 0x20 <- 0x0000_0042 -> ack comes 1 edge after accept; the read returns 0x0000_0042.
